// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: bundles the two requester ports and the RAM-side bus
// of the arbiter.
//   m0_* / m1_*  request channel: req, we, addr, wdata in; ack, rdata out
//   ram_*        registered addr/wdata/we/oe out; ram_rdata in
//   busy, owner  arbiter status
// Modports:
//   slave  - arbiter view (serves the masters, drives the RAM)
//   master - environment view (requesters plus RAM)
interface ram_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              m0_req, m0_we, m0_ack;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_ack;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_we, ram_oe;
  logic              busy, owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output ram_addr, ram_wdata, ram_we, ram_oe,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_oe,
    input  busy, owner
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one single-port RAM between the CPU (m0) and the
// loader/DMA engine (m1). Every transaction is an ARB cycle followed by one
// ACCESS cycle. m0 has fixed priority, but after MAX_HOLD consecutive m0
// grants with m1 waiting, m1 is served next.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - slave modport: m0/m1 request channels, RAM bus, busy/owner
module ram_bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  ram_bus_arbiter_if.slave   bus
);

  typedef enum logic {ARB = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_oe_q, ram_oe_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic              pick_m1;
  logic              win_we;

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_oe_d    = 1'b0;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    pick_m1     = bus.m1_req & (~bus.m0_req | (starve_q == HOLD_LIM));
    win_we      = pick_m1 ? bus.m1_we : bus.m0_we;

    case (state_q)
      ARB: begin
        if (bus.m0_req | bus.m1_req) begin
          state_d     = ACCESS;
          owner_d     = pick_m1;
          ram_addr_d  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
          ram_wdata_d = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
          // Strobes and ack are registered so they appear exactly in ACCESS.
          ram_we_d    = win_we;
          ram_oe_d    = ~win_we;
          m0_ack_d    = ~pick_m1;
          m1_ack_d    = pick_m1;
          if (pick_m1)
            starve_d = '0;
          else if (bus.m1_req && starve_q != HOLD_LIM)
            starve_d = starve_q + 4'd1;
        end
        // No one waiting on the low-priority side: nothing to protect.
        if (!bus.m1_req) starve_d = '0;
      end
      ACCESS: begin
        state_d = ARB;
        if (ram_oe_q) begin
          if (owner_q) m1_rdata_d = bus.ram_rdata;
          else         m0_rdata_d = bus.ram_rdata;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      owner_q     <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_oe    = ram_oe_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == ACCESS);

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed test of the two-master RAM arbiter with a
// behavioural 256x8 RAM attached to the RAM side of the bus.
module tb_ram_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  logic [7:0] mem [256];
  int n_assert = 0;
  int n_fail   = 0;

  ram_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on the edge closing ACCESS.
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h5A;
      mem[8'h01] <= 8'h11;
      mem[8'h02] <= 8'h22;
      mem[8'h03] <= 8'h33;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] grant_exp;
    logic [9:0] seq_exp;
    reset = 1'b1;
    mem_init = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    #2;
    chk("rst_we",    bus.ram_we, 0);
    chk("rst_oe",    bus.ram_oe, 0);
    chk("rst_acks",  {bus.m0_ack, bus.m1_ack}, 0);
    chk("rst_addr",  bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
    chk("rst_own_busy", {bus.owner, bus.busy}, 0);
    #10;               // t=12, after the preload edge at t=5
    reset = 1'b0;
    mem_init = 1'b0;
    tick();            // idle ARB
    chk("idle_busy", bus.busy, 0);

    // m0 read of 0x10 (holds 0x5A)
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h10;
    tick();
    chk("m0rd_oe",   bus.ram_oe, 1);
    chk("m0rd_we",   bus.ram_we, 0);
    chk("m0rd_ack",  {bus.m0_ack, bus.m1_ack}, 2'b10);
    chk("m0rd_addr", bus.ram_addr, 8'h10);
    chk("m0rd_busy", bus.busy, 1);
    bus.m0_req = 0;
    tick();
    chk("m0rd_ackoff", {bus.m0_ack, bus.m1_ack, bus.ram_oe, bus.busy}, 0);
    chk("m0rd_rdata",  bus.m0_rdata, 8'h5A);

    // m1 write alone
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 8'h20; bus.m1_wdata = 8'hC3;
    tick();
    chk("m1wr_we",    {bus.ram_we, bus.ram_oe}, 2'b10);
    chk("m1wr_addr",  bus.ram_addr, 8'h20);
    chk("m1wr_wdata", bus.ram_wdata, 8'hC3);
    chk("m1wr_owner", bus.owner, 1);
    chk("m1wr_ack",   {bus.m0_ack, bus.m1_ack}, 2'b01);
    bus.m1_req = 0;
    tick();
    chk("m1wr_mem",   mem[8'h20], 8'hC3);
    chk("m1wr_hold",  {bus.ram_addr, bus.ram_wdata}, 16'h20C3);
    chk("m1wr_idle",  {bus.ram_we, bus.m1_ack, bus.busy}, 0);
    chk("m1wr_rdata", bus.m1_rdata, 0);

    // Simultaneous reads: m0 first, m1 in the next pair
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h10;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 8'h20;
    tick();
    chk("sim_first", {bus.m0_ack, bus.m1_ack, bus.owner}, 3'b100);
    bus.m0_req = 0;
    tick();
    chk("sim_gap", {bus.m0_ack, bus.m1_ack, bus.busy}, 0);
    tick();
    chk("sim_second", {bus.m0_ack, bus.m1_ack, bus.owner}, 3'b011);
    chk("sim_addr", bus.ram_addr, 8'h20);
    bus.m1_req = 0;
    tick();
    chk("sim_rdata", {bus.m0_rdata, bus.m1_rdata}, 16'h5AC3);

    // Starvation limit: both held, expect m0 x4 then m1, twice
    seq_exp = 10'b1000010000;   // bit i = owner of grant i
    bus.m0_req = 1; bus.m0_addr = 8'h10;
    bus.m1_req = 1; bus.m1_addr = 8'h20;
    for (int g = 0; g < 10; g++) begin
      tick();
      grant_exp = {1'b1, seq_exp[g], ~seq_exp[g], seq_exp[g], 1'b0};
      chk($sformatf("starve_g%0d", g),
          {bus.busy, bus.owner, bus.m0_ack, bus.m1_ack, bus.m0_ack & bus.m1_ack}, grant_exp);
      if (g == 9) begin bus.m0_req = 0; bus.m1_req = 0; end
      tick();
    end
    chk("starve_end", {bus.busy, bus.m0_ack, bus.m1_ack}, 0);

    // Back-to-back m0 reads 1,2,3
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h01;
    for (int a = 1; a <= 3; a++) begin
      tick();
      chk($sformatf("b2b_acc%0d", a), {bus.busy, bus.m0_ack, bus.ram_addr}, {2'b11, 8'(a)});
      if (a < 3) bus.m0_addr = 8'(a + 1);
      else       bus.m0_req = 0;
      tick();
      chk($sformatf("b2b_arb%0d", a), {bus.busy, bus.m0_ack, bus.m0_rdata}, {2'b00, 8'(a * 8'h11)});
    end

    // Reset in the middle of an m0 write to 0x30
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 8'h30; bus.m0_wdata = 8'h77;
    tick();
    chk("rma_pre", {bus.ram_we, bus.m0_ack, bus.busy}, 3'b111);
    reset = 1'b1;
    bus.m0_req = 0;
    #1;
    chk("rma_strobe", {bus.ram_we, bus.ram_oe, bus.m0_ack, bus.m1_ack, bus.busy}, 0);
    chk("rma_bus",    {bus.ram_addr, bus.ram_wdata}, 0);
    chk("rma_rdata",  {bus.m0_rdata, bus.m1_rdata, bus.owner}, 0);
    #5;
    reset = 1'b0;
    tick();
    chk("rma_mem",  mem[8'h30], 0);
    chk("rma_idle", {bus.busy, bus.ram_we, bus.m0_ack}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
Two-master arbiter that shares the single-port 8-bit RAM between the CPU (master 0) and the program loader/DMA engine (master 1). It sequences every RAM transaction as a two-cycle ARB→ACCESS pair and registers all RAM control, address and data lines. Master 0 has fixed priority, with a starvation limit that guarantees master 1 service. It sits between the masters and the ram instance in the machine top level, replacing direct CPU drive of ram we/oe.

Parameters:
ADDR_W, 8, address width of masters and RAM
DATA_W, 8, data width
MAX_HOLD, 4, max consecutive m0 grants while m1_req is pending; range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  CPU access request; held until m0_ack
m0_we  input  1  1=write, 0=read
m0_addr  input  ADDR_W  CPU address
m0_wdata  input  DATA_W  CPU write data
m0_ack  output  1  high for exactly the ACCESS cycle of an m0 transaction
m0_rdata  output  DATA_W  m0 read data, registered
m1_req, m1_we, m1_addr, m1_wdata  input  1/1/ADDR_W/DATA_W  loader request, same rules as m0
m1_ack  output  1  as m0_ack
m1_rdata  output  DATA_W  as m0_rdata
ram_addr  output  ADDR_W  registered RAM address
ram_wdata  output  DATA_W  registered RAM write data
ram_we  output  1  RAM write enable
ram_oe  output  1  RAM output enable
ram_rdata  input  DATA_W  RAM read data, combinationally valid while ram_oe high
busy  output  1  high in ACCESS
owner  output  1  master of the current or last transaction

Behaviour:
- Reset (async, immediate): state=ARB; ram_we=ram_oe=0; m0_ack=m1_ack=0; ram_addr, ram_wdata, m0_rdata, m1_rdata all 0; owner=0; busy=0; starve counter=0.
- ARB state:
  - no req: stay in ARB.
  - Otherwise pick the winner: m1 if (m1_req & !m0_req) or (m1_req & starve_cnt==MAX_HOLD); else m0.
  - Latch winner addr/wdata/we into ram_addr/ram_wdata/we_q and set owner; next state ACCESS.
- ACCESS state (exactly 1 cycle):
  - ram_we=we_q, ram_oe=!we_q; ram_we and ram_oe are never both high.
  - busy=1; ack of owner=1, other ack=0.
  - On a read, at the closing edge capture ram_rdata into owner's rdata.
  - Next state: ARB.
- Requester handshake: sample ack on the edge closing ACCESS; at that same edge either drop req or present the next request's fields. req high in ARB always starts a new transaction.
- Throughput: one transaction per 2 cycles per arbiter. Latency: req seen in ARB → ack in the following cycle.
- Idle outputs: ram_addr/ram_wdata hold their last value outside ACCESS. rdata holds until the same master's next read completes; writes leave rdata unchanged.
- Starve counter:
  - increments (saturating at MAX_HOLD) on each m0 grant made while m1_req=1;
  - clears on any m1 grant or when m1_req=0 in ARB.
- Request changes: req or fields changing while not in ARB are ignored until the next ARB.
- Reset mid-ACCESS: RAM strobes and ack drop immediately. The transaction is lost; no rdata update.

Test Plan:
- Reset, then m0 read: ram @0x10 holds 0x5A, m0_req=1, m0_we=0, m0_addr=0x10 → ram_oe=1 and m0_ack=1 in cycle 2 only; m0_rdata=0x5A from cycle 3; m1_ack stays 0.
- m1 write alone: m1_addr=0x20, m1_wdata=0xC3 → one ACCESS cycle with ram_we=1, ram_addr=0x20, ram_wdata=0xC3, owner=1; RAM then reads 0xC3.
- Simultaneous single requests: m0 and m1 requesting in the same ARB cycle → m0 served first, m1 in the next pair; acks 2 cycles apart, never overlapping.
- Starvation, MAX_HOLD=4: m0_req and m1_req held continuously → grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1…
- Reset mid-ACCESS of an m0 write to 0x30 → ram_we and m0_ack drop within the reset cycle; state=ARB; all outputs at reset values.
- Back-to-back m0 reads: addrs 0x01, 0x02, 0x03 presented at each ack edge → acks every other cycle; m0_rdata tracks RAM contents in order; busy toggles 0,1,0,1…
